// File: rtl/picorv32_arb_pkg.sv
// Shared types for the two-master picorv32 native-bus arbiter.
// Pure declarations; no logic, no latency, no backpressure.
package picorv32_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_e;

  localparam int TO_CNT_W = 16;

  typedef logic mst_idx_t;

endpackage

// File: rtl/picorv32_mem_arbiter.sv
// Round-robin share of one picorv32 memory bus between m0/m1; grant registered one edge after valid, idle cycle between grants.
// Masters are stalled via mN_mem_ready until the downstream completes or the timeout forces completion.
module picorv32_mem_arbiter
  import picorv32_arb_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_RDATA  = 32'hdead_beef,
  parameter int          PRIO_INIT      = 0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_mem_valid,
  input  logic        m0_mem_instr,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic        m0_mem_ready,
  output logic [31:0] m0_mem_rdata,

  input  logic        m1_mem_valid,
  input  logic        m1_mem_instr,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic        m1_mem_ready,
  output logic [31:0] m1_mem_rdata,

  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,

  output logic        timeout_err
);

  localparam bit                    TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_W-1:0]   TO_LAST = TO_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam mst_idx_t              LAST_RST = ~mst_idx_t'(PRIO_INIT);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  mst_idx_t            r_last_grant;
  mst_idx_t            w_winner;
  logic                w_grant;
  logic                w_busy;
  logic                w_timeout;
  logic                w_done;
  logic [TO_CNT_W-1:0] r_cnt;

  logic                r_mem_valid;
  logic                r_mem_instr;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [3:0]          r_mem_wstrb;
  logic                r_timeout_err;

  always_comb begin
    w_winner    = 1'b0;
    w_grant     = 1'b0;
    w_busy      = (r_state != IDLE);
    w_timeout   = 1'b0;
    w_done      = 1'b0;
    w_state_nxt = r_state;

    // On a tie the master that did not win last time gets the bus.
    if (m0_mem_valid && m1_mem_valid) w_winner = ~r_last_grant;
    else if (m1_mem_valid)            w_winner = 1'b1;

    if (TO_EN && w_busy && !mem_ready && (r_cnt == TO_LAST)) w_timeout = 1'b1;
    w_done = w_busy && (mem_ready || w_timeout);

    case (r_state)
      IDLE: begin
        if (m0_mem_valid || m1_mem_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = w_winner ? BUSY1 : BUSY0;
        end
      end
      BUSY0, BUSY1: begin
        if (w_done) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_last_grant  <= LAST_RST;
      r_cnt         <= '0;
      r_mem_valid   <= 1'b0;
      r_mem_instr   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wstrb   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timeout_err <= w_timeout;
      if (w_grant) begin
        r_last_grant <= w_winner;
        r_cnt        <= '0;
        r_mem_valid  <= 1'b1;
        r_mem_instr  <= w_winner ? m1_mem_instr : m0_mem_instr;
        r_mem_addr   <= w_winner ? m1_mem_addr  : m0_mem_addr;
        r_mem_wdata  <= w_winner ? m1_mem_wdata : m0_mem_wdata;
        r_mem_wstrb  <= w_winner ? m1_mem_wstrb : m0_mem_wstrb;
      end else if (w_done) begin
        r_mem_valid <= 1'b0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign mem_valid   = r_mem_valid;
  assign mem_instr   = r_mem_instr;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_wstrb   = r_mem_wstrb;
  assign timeout_err = r_timeout_err;

  // Completion is steered only to the granted master; a stray mem_ready in IDLE goes nowhere.
  assign m0_mem_ready = (r_state == BUSY0) && (mem_ready || w_timeout);
  assign m1_mem_ready = (r_state == BUSY1) && (mem_ready || w_timeout);
  assign m0_mem_rdata = (r_state == BUSY0) ? (w_timeout ? TIMEOUT_RDATA : mem_rdata) : '0;
  assign m1_mem_rdata = (r_state == BUSY1) ? (w_timeout ? TIMEOUT_RDATA : mem_rdata) : '0;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Directed bench for picorv32_mem_arbiter: read, write, contention, timeout, race, reset.
module tb_picorv32_mem_arbiter;

  logic        clk;
  logic        resetn;
  logic        m0_mem_valid, m0_mem_instr, m0_mem_ready;
  logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
  logic [3:0]  m0_mem_wstrb;
  logic        m1_mem_valid, m1_mem_instr, m1_mem_ready;
  logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
  logic [3:0]  m1_mem_wstrb;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  picorv32_mem_arbiter #(
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_RDATA (32'hdead_beef),
    .PRIO_INIT     (0)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .m0_mem_valid (m0_mem_valid),
    .m0_mem_instr (m0_mem_instr),
    .m0_mem_addr  (m0_mem_addr),
    .m0_mem_wdata (m0_mem_wdata),
    .m0_mem_wstrb (m0_mem_wstrb),
    .m0_mem_ready (m0_mem_ready),
    .m0_mem_rdata (m0_mem_rdata),
    .m1_mem_valid (m1_mem_valid),
    .m1_mem_instr (m1_mem_instr),
    .m1_mem_addr  (m1_mem_addr),
    .m1_mem_wdata (m1_mem_wdata),
    .m1_mem_wstrb (m1_mem_wstrb),
    .m1_mem_ready (m1_mem_ready),
    .m1_mem_rdata (m1_mem_rdata),
    .mem_valid    (mem_valid),
    .mem_instr    (mem_instr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    m0_mem_valid = 0; m0_mem_instr = 0; m0_mem_addr = 0; m0_mem_wdata = 0; m0_mem_wstrb = 0;
    m1_mem_valid = 0; m1_mem_instr = 0; m1_mem_addr = 0; m1_mem_wdata = 0; m1_mem_wstrb = 0;
    mem_ready = 0; mem_rdata = 0;
    step(); step();
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_m0_ready", 32'(m0_mem_ready), 32'd0);
    chk("rst_m1_ready", 32'(m1_mem_ready), 32'd0);
    resetn = 1'b1;
    step();

    // Single read by m0, memory answers in the 3rd busy cycle
    m0_mem_valid = 1; m0_mem_addr = 32'h100; m0_mem_wstrb = 4'h0;
    #1;
    chk("rd_no_comb_path", 32'(mem_valid), 32'd0);
    step();
    chk("rd_mem_valid", 32'(mem_valid), 32'd1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    chk("rd_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rd_m0_ready_c1", 32'(m0_mem_ready), 32'd0);
    step();
    chk("rd_m0_ready_c2", 32'(m0_mem_ready), 32'd0);
    step();
    mem_ready = 1; mem_rdata = 32'h1234_5678;
    #1;
    chk("rd_m0_ready", 32'(m0_mem_ready), 32'd1);
    chk("rd_m0_rdata", m0_mem_rdata, 32'h1234_5678);
    chk("rd_m1_ready", 32'(m1_mem_ready), 32'd0);
    chk("rd_m1_rdata", m1_mem_rdata, 32'd0);
    step();
    m0_mem_valid = 0; mem_ready = 0;
    chk("rd_done_valid", 32'(mem_valid), 32'd0);

    // Stray downstream ready while idle
    mem_ready = 1;
    #1;
    chk("stray_m0_ready", 32'(m0_mem_ready), 32'd0);
    chk("stray_m1_ready", 32'(m1_mem_ready), 32'd0);
    step();
    mem_ready = 0;
    chk("stray_no_grant", 32'(mem_valid), 32'd0);

    // Write forwarding from m1
    m1_mem_valid = 1; m1_mem_addr = 32'h200; m1_mem_wdata = 32'hcafe_babe; m1_mem_wstrb = 4'b0011;
    step();
    chk("wr_mem_valid", 32'(mem_valid), 32'd1);
    chk("wr_mem_addr", mem_addr, 32'h200);
    chk("wr_mem_wdata", mem_wdata, 32'hcafe_babe);
    chk("wr_mem_wstrb", 32'(mem_wstrb), 32'h3);
    step();
    chk("wr_hold_wdata", mem_wdata, 32'hcafe_babe);
    chk("wr_hold_wstrb", 32'(mem_wstrb), 32'h3);
    chk("wr_hold_m1_ready", 32'(m1_mem_ready), 32'd0);
    step();
    chk("wr_hold_valid", 32'(mem_valid), 32'd1);
    mem_ready = 1; mem_rdata = 32'h0000_0055;
    #1;
    chk("wr_m1_ready", 32'(m1_mem_ready), 32'd1);
    chk("wr_m1_rdata", m1_mem_rdata, 32'h55);
    chk("wr_m0_ready", 32'(m0_mem_ready), 32'd0);
    chk("wr_m0_rdata", m0_mem_rdata, 32'd0);
    step();
    m1_mem_valid = 0; mem_ready = 0;
    chk("wr_done_valid", 32'(mem_valid), 32'd0);

    // Timeout on m0: memory never answers
    m0_mem_valid = 1; m0_mem_addr = 32'h300; m0_mem_wstrb = 4'h0;
    step();
    chk("to_c1_ready", 32'(m0_mem_ready), 32'd0);
    step();
    chk("to_c2_ready", 32'(m0_mem_ready), 32'd0);
    step();
    chk("to_c3_ready", 32'(m0_mem_ready), 32'd0);
    step();
    chk("to_c4_ready", 32'(m0_mem_ready), 32'd1);
    chk("to_c4_rdata", m0_mem_rdata, 32'hdead_beef);
    chk("to_c4_err_not_yet", 32'(timeout_err), 32'd0);
    step();
    m0_mem_valid = 0;
    chk("to_err_pulse", 32'(timeout_err), 32'd1);
    chk("to_mem_valid_clr", 32'(mem_valid), 32'd0);
    chk("to_m0_ready_clr", 32'(m0_mem_ready), 32'd0);
    m1_mem_valid = 1; m1_mem_addr = 32'h400; m1_mem_wdata = 0; m1_mem_wstrb = 0;
    step();
    chk("to_err_single", 32'(timeout_err), 32'd0);
    chk("to_next_valid", 32'(mem_valid), 32'd1);
    chk("to_next_addr", mem_addr, 32'h400);
    mem_ready = 1; mem_rdata = 32'h0000_a5a5;
    #1;
    chk("to_next_m1_ready", 32'(m1_mem_ready), 32'd1);
    chk("to_next_m1_rdata", m1_mem_rdata, 32'ha5a5);
    step();
    m1_mem_valid = 0; mem_ready = 0;

    // Race: memory answers in the timeout cycle
    m0_mem_valid = 1; m0_mem_addr = 32'h500;
    step(); step(); step(); step();
    mem_ready = 1; mem_rdata = 32'h0bad_f00d;
    #1;
    chk("race_m0_ready", 32'(m0_mem_ready), 32'd1);
    chk("race_m0_rdata", m0_mem_rdata, 32'h0bad_f00d);
    step();
    m0_mem_valid = 0; mem_ready = 0;
    chk("race_no_err", 32'(timeout_err), 32'd0);
    chk("race_valid_clr", 32'(mem_valid), 32'd0);
    step();
    chk("race_no_err_later", 32'(timeout_err), 32'd0);

    // Contention from reset with memory always ready
    resetn = 0;
    m0_mem_valid = 1; m0_mem_instr = 1; m0_mem_addr = 32'ha00;
    m1_mem_valid = 1; m1_mem_instr = 0; m1_mem_addr = 32'hb00;
    mem_ready = 1; mem_rdata = 0;
    step();
    resetn = 1;
    for (int g = 0; g < 4; g++) begin
      step();
      chk("cont_valid", 32'(mem_valid), 32'd1);
      chk("cont_addr", mem_addr, (g % 2 == 0) ? 32'ha00 : 32'hb00);
      chk("cont_instr", 32'(mem_instr), (g % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_m0_ready", 32'(m0_mem_ready), (g % 2 == 0) ? 32'd1 : 32'd0);
      chk("cont_m1_ready", 32'(m1_mem_ready), (g % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk("cont_gap", 32'(mem_valid), 32'd0);
    end
    m0_mem_valid = 0; m1_mem_valid = 0; m0_mem_instr = 0; mem_ready = 0;
    step();

    // Asynchronous reset while m1 is being served
    m1_mem_valid = 1; m1_mem_addr = 32'hc00;
    step();
    chk("arst_pre_valid", 32'(mem_valid), 32'd1);
    #2;
    resetn = 0;
    #1;
    chk("arst_valid_drop", 32'(mem_valid), 32'd0);
    chk("arst_m1_ready", 32'(m1_mem_ready), 32'd0);
    step();
    resetn = 1;
    step();
    chk("arst_regrant_valid", 32'(mem_valid), 32'd1);
    chk("arst_regrant_addr", mem_addr, 32'hc00);
    mem_ready = 1; mem_rdata = 32'h0000_0c0c;
    #1;
    chk("arst_regrant_m1_ready", 32'(m1_mem_ready), 32'd1);
    chk("arst_regrant_m1_rdata", m1_mem_rdata, 32'h0c0c);
    step();
    m1_mem_valid = 0; mem_ready = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
